// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ID/EX stage: ALUOp selectors, R-type funct codes
// and the 4-bit ALUCtr codes understood by mips_alu.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  localparam logic [3:0] ALUCTR_AND  = 4'b0000;
  localparam logic [3:0] ALUCTR_OR   = 4'b0001;
  localparam logic [3:0] ALUCTR_ADD  = 4'b0010;
  localparam logic [3:0] ALUCTR_SLL  = 4'b0100;
  localparam logic [3:0] ALUCTR_SRL  = 4'b0101;
  localparam logic [3:0] ALUCTR_SUB  = 4'b0110;
  localparam logic [3:0] ALUCTR_SLT  = 4'b0111;
  localparam logic [3:0] ALUCTR_NOR  = 4'b1100;
  localparam logic [3:0] ALUCTR_NONE = 4'b1111;

endpackage

// File: rtl/mips_id_ex_stage_if.sv
// Signal bundle between ID, the ID/EX stage, the forwarding sources and the EX consumers.
// slave = the ID/EX stage itself, master = whoever drives ID and observes EX.
interface mips_id_ex_stage_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [DATA_W-1:0]     id_readData1;
  logic [DATA_W-1:0]     id_readData2;
  logic [DATA_W-1:0]     id_imm;
  logic [4:0]            id_shamt;
  logic [5:0]            id_funct;
  logic [1:0]            id_ALUOp;
  logic                  id_ALUSrc;
  logic                  id_RegDst;
  logic                  id_RegWrite;
  logic                  id_MemRead;
  logic                  id_MemWrite;
  logic                  id_MemtoReg;
  logic                  hold;
  logic                  flush;
  logic                  exmem_RegWrite;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [DATA_W-1:0]     exmem_result;
  logic                  memwb_RegWrite;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [DATA_W-1:0]     memwb_data;
  logic [DATA_W-1:0]     readData1;
  logic [DATA_W-1:0]     readData2;
  logic [4:0]            shamt;
  logic [3:0]            ALUCtr;
  logic [DATA_W-1:0]     ex_storeData;
  logic [REG_ADDR_W-1:0] ex_writeReg;
  logic                  ex_RegWrite;
  logic                  ex_MemRead;
  logic                  ex_MemWrite;
  logic                  ex_MemtoReg;
  logic                  loadUseHazard;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_readData1, id_readData2, id_imm,
           id_shamt, id_funct, id_ALUOp, id_ALUSrc, id_RegDst, id_RegWrite,
           id_MemRead, id_MemWrite, id_MemtoReg, hold, flush,
           exmem_RegWrite, exmem_rd, exmem_result, memwb_RegWrite, memwb_rd, memwb_data,
    input  readData1, readData2, shamt, ALUCtr, ex_storeData, ex_writeReg,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, loadUseHazard
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_readData1, id_readData2, id_imm,
           id_shamt, id_funct, id_ALUOp, id_ALUSrc, id_RegDst, id_RegWrite,
           id_MemRead, id_MemWrite, id_MemtoReg, hold, flush,
           exmem_RegWrite, exmem_rd, exmem_result, memwb_RegWrite, memwb_rd, memwb_data,
    output readData1, readData2, shamt, ALUCtr, ex_storeData, ex_writeReg,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, loadUseHazard
  );
endinterface

// File: rtl/mips_alu_control.sv
// Combinational ALUOp/funct -> ALUCtr decode; unknown R-type funct maps to the
// "result 0" code so the ALU never performs an unintended operation.
module mips_alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr
);

  always_comb begin
    alu_ctr = ALUCTR_NONE;
    case (alu_op)
      ALUOP_ADD: alu_ctr = ALUCTR_ADD;
      ALUOP_SUB: alu_ctr = ALUCTR_SUB;
      ALUOP_OR:  alu_ctr = ALUCTR_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctr = ALUCTR_ADD;
          FUNCT_SUB: alu_ctr = ALUCTR_SUB;
          FUNCT_AND: alu_ctr = ALUCTR_AND;
          FUNCT_OR:  alu_ctr = ALUCTR_OR;
          FUNCT_NOR: alu_ctr = ALUCTR_NOR;
          FUNCT_SLT: alu_ctr = ALUCTR_SLT;
          FUNCT_SLL: alu_ctr = ALUCTR_SLL;
          FUNCT_SRL: alu_ctr = ALUCTR_SRL;
          default:   alu_ctr = ALUCTR_NONE;
        endcase
      end
      default: alu_ctr = ALUCTR_NONE;
    endcase
  end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register: latches decode, derives ALUCtr, selects ALU operands, detects load-use.
// Build option MIPS_FORWARD_EN: EX/MEM + MEM/WB forwarding; when undefined, a pure stall interlock.
module mips_id_ex_stage
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input logic               clk,
  input logic               reset,
  mips_id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [4:0]            shamt;
    logic [3:0]            alu_ctr;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } ex_reg_t;

  ex_reg_t           ex_q;
  ex_reg_t           ex_d;
  logic [3:0]        alu_ctr_s;
  logic              load_use_s;
  logic              ex_match_s;
  logic [DATA_W-1:0] fwd_rs_s;
  logic [DATA_W-1:0] fwd_rt_s;

  mips_alu_control u_alu_control (
    .alu_op  (bus.id_ALUOp),
    .funct   (bus.id_funct),
    .alu_ctr (alu_ctr_s)
  );

  assign ex_match_s = (ex_q.write_reg != '0) &&
                      ((ex_q.write_reg == bus.id_rs) || (ex_q.write_reg == bus.id_rt));

`ifdef MIPS_FORWARD_EN
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_W-1:0]     rf_val,
    input logic                  exmem_we,
    input logic [REG_ADDR_W-1:0] exmem_rd,
    input logic [DATA_W-1:0]     exmem_val,
    input logic                  memwb_we,
    input logic [REG_ADDR_W-1:0] memwb_rd,
    input logic [DATA_W-1:0]     memwb_val
  );
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
      return exmem_val;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
      return memwb_val;
    end else begin
      return rf_val;
    end
  endfunction

  assign fwd_rs_s = fwd_operand(ex_q.rs, ex_q.rd1, bus.exmem_RegWrite, bus.exmem_rd,
                                bus.exmem_result, bus.memwb_RegWrite, bus.memwb_rd, bus.memwb_data);
  assign fwd_rt_s = fwd_operand(ex_q.rt, ex_q.rd2, bus.exmem_RegWrite, bus.exmem_rd,
                                bus.exmem_result, bus.memwb_RegWrite, bus.memwb_rd, bus.memwb_data);
  assign load_use_s = bus.id_valid && ex_q.mem_read && ex_match_s;
`else
  logic mem_match_s;

  // Without forwarding, any in-flight producer of an ID source must stall ID.
  assign mem_match_s = bus.exmem_RegWrite && (bus.exmem_rd != '0) &&
                       ((bus.exmem_rd == bus.id_rs) || (bus.exmem_rd == bus.id_rt));
  assign fwd_rs_s    = ex_q.rd1;
  assign fwd_rt_s    = ex_q.rd2;
  assign load_use_s  = bus.id_valid &&
                       ((ex_match_s && (ex_q.mem_read || ex_q.reg_write)) || mem_match_s);
`endif

  // Next-state: hold keeps contents, bubbles zero everything, otherwise load from ID.
  always_comb begin
    ex_d = ex_q;
    if (bus.hold) begin
      ex_d = ex_q;
    end else if (bus.flush || load_use_s || !bus.id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.rs         = bus.id_rs;
      ex_d.rt         = bus.id_rt;
      ex_d.write_reg  = bus.id_RegDst ? bus.id_rd : bus.id_rt;
      ex_d.rd1        = bus.id_readData1;
      ex_d.rd2        = bus.id_readData2;
      ex_d.imm        = bus.id_imm;
      ex_d.shamt      = bus.id_shamt;
      ex_d.alu_ctr    = alu_ctr_s;
      ex_d.alu_src    = bus.id_ALUSrc;
      ex_d.reg_write  = bus.id_RegWrite;
      ex_d.mem_read   = bus.id_MemRead;
      ex_d.mem_write  = bus.id_MemWrite;
      ex_d.mem_to_reg = bus.id_MemtoReg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.readData1     = fwd_rs_s;
  assign bus.readData2     = ex_q.alu_src ? ex_q.imm : fwd_rt_s;
  assign bus.ex_storeData  = fwd_rt_s;
  assign bus.shamt         = ex_q.shamt;
  assign bus.ALUCtr        = ex_q.alu_ctr;
  assign bus.ex_writeReg   = ex_q.write_reg;
  assign bus.ex_RegWrite   = ex_q.reg_write;
  assign bus.ex_MemRead    = ex_q.mem_read;
  assign bus.ex_MemWrite   = ex_q.mem_write;
  assign bus.ex_MemtoReg   = ex_q.mem_to_reg;
  assign bus.loadUseHazard = load_use_s;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Directed self-checking bench for mips_id_ex_stage; expectations follow MIPS_FORWARD_EN.
module tb_mips_id_ex_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_id_ex_stage_if bus ();

  mips_id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {ALUOp, funct, expected ALUCtr}
  localparam logic [11:0] ALU_VEC [12] = '{
    {2'b00, 6'b111111, 4'b0010}, {2'b01, 6'b111111, 4'b0110}, {2'b11, 6'b111111, 4'b0001},
    {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100010, 4'b0110}, {2'b10, 6'b100100, 4'b0000},
    {2'b10, 6'b100101, 4'b0001}, {2'b10, 6'b100111, 4'b1100}, {2'b10, 6'b101010, 4'b0111},
    {2'b10, 6'b000000, 4'b0100}, {2'b10, 6'b000010, 4'b0101}, {2'b10, 6'b111111, 4'b1111}
  };

`ifdef MIPS_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [4:0] sh, input logic [5:0] funct,
                        input logic [1:0] op, input logic [5:0] ctl);
    bus.id_valid = valid;  bus.id_rs = rs;  bus.id_rt = rt;  bus.id_rd = rd;
    bus.id_readData1 = rd1;  bus.id_readData2 = rd2;  bus.id_imm = imm;
    bus.id_shamt = sh;  bus.id_funct = funct;  bus.id_ALUOp = op;
    // ctl = {ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg}
    {bus.id_ALUSrc, bus.id_RegDst, bus.id_RegWrite,
     bus.id_MemRead, bus.id_MemWrite, bus.id_MemtoReg} = ctl;
  endtask

  task automatic clear_fwd();
    bus.exmem_RegWrite = 1'b0;  bus.exmem_rd = 5'd0;  bus.exmem_result = 32'd0;
    bus.memwb_RegWrite = 1'b0;  bus.memwb_rd = 5'd0;  bus.memwb_data = 32'd0;
  endtask

  task automatic test_reset();
    bus.hold = 1'b0;  bus.flush = 1'b0;  clear_fwd();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 6'b100000, 2'b10, 6'b011000);
    reset = 1'b1;
    step();  step();
    n_cmp++; if ({bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg} !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg}); end
    n_cmp++; if (bus.ALUCtr !== 4'b0000) begin n_err++; $display("FAIL reset_aluctr: got %b want 0000", bus.ALUCtr); end
    n_cmp++; if (bus.readData1 !== 32'd0 || bus.readData2 !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", bus.readData1, bus.readData2); end
    reset = 1'b0;
    step();
    n_cmp++; if (bus.ex_RegWrite !== 1'b1) begin n_err++; $display("FAIL reset_reload: got %b want 1", bus.ex_RegWrite); end
    reset = 1'b1;  bus.hold = 1'b1;
    step();
    n_cmp++; if (bus.ex_RegWrite !== 1'b0 || bus.ALUCtr !== 4'b0000 || bus.ex_writeReg !== 5'd0) begin n_err++; $display("FAIL reset_over_hold: got rw=%b ctr=%b wr=%0d want 0/0000/0", bus.ex_RegWrite, bus.ALUCtr, bus.ex_writeReg); end
    reset = 1'b0;  bus.hold = 1'b0;
  endtask

  task automatic test_add();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0000_0100, 5'd0, 6'b100000, 2'b10, 6'b011000);
    step();
    n_cmp++; if (bus.readData1 !== 32'd5) begin n_err++; $display("FAIL add_rd1: got %h want 5", bus.readData1); end
    n_cmp++; if (bus.readData2 !== 32'd7) begin n_err++; $display("FAIL add_rd2: got %h want 7", bus.readData2); end
    n_cmp++; if (bus.ALUCtr !== 4'b0010) begin n_err++; $display("FAIL add_aluctr: got %b want 0010", bus.ALUCtr); end
    n_cmp++; if (bus.ex_writeReg !== 5'd3 || bus.ex_RegWrite !== 1'b1) begin n_err++; $display("FAIL add_wr: got %0d/%b want 3/1", bus.ex_writeReg, bus.ex_RegWrite); end
    // addi $9,$1,0x100: immediate operand, rt destination
    set_id(1'b1, 5'd1, 5'd9, 5'd17, 32'd5, 32'h55, 32'h0000_0100, 5'd0, 6'b000000, 2'b00, 6'b101000);
    step();
    n_cmp++; if (bus.readData2 !== 32'h100 || bus.ex_storeData !== 32'h55) begin n_err++; $display("FAIL addi_imm: got %h/%h want 100/55", bus.readData2, bus.ex_storeData); end
    n_cmp++; if (bus.ex_writeReg !== 5'd9) begin n_err++; $display("FAIL addi_wr: got %0d want 9", bus.ex_writeReg); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    set_id(1'b1, 5'd4, 5'd4, 5'd9, 32'hAA, 32'hBB, 32'd0, 5'd0, 6'b100000, 2'b10, 6'b011000);
    step();
    bus.id_valid = 1'b0;
    bus.exmem_RegWrite = 1'b1;  bus.exmem_rd = 5'd4;  bus.exmem_result = 32'h10;
    bus.memwb_RegWrite = 1'b1;  bus.memwb_rd = 5'd4;  bus.memwb_data = 32'h20;
    #1;
    exp_a = FWD ? 32'h10 : 32'hAA;  exp_b = FWD ? 32'h10 : 32'hBB;
    n_cmp++; if (bus.readData1 !== exp_a || bus.readData2 !== exp_b || bus.ex_storeData !== exp_b) begin n_err++; $display("FAIL fwd_exmem: got %h/%h/%h want %h/%h/%h", bus.readData1, bus.readData2, bus.ex_storeData, exp_a, exp_b, exp_b); end
    bus.exmem_RegWrite = 1'b0;
    #1;
    exp_a = FWD ? 32'h20 : 32'hAA;  exp_b = FWD ? 32'h20 : 32'hBB;
    n_cmp++; if (bus.readData1 !== exp_a || bus.readData2 !== exp_b) begin n_err++; $display("FAIL fwd_memwb: got %h/%h want %h/%h", bus.readData1, bus.readData2, exp_a, exp_b); end
    bus.exmem_RegWrite = 1'b1;  bus.exmem_rd = 5'd7;
    #1;
    n_cmp++; if (bus.readData1 !== exp_a) begin n_err++; $display("FAIL fwd_memwb_other: got %h want %h", bus.readData1, exp_a); end
    bus.exmem_rd = 5'd0;  bus.memwb_rd = 5'd0;
    #1;
    n_cmp++; if (bus.readData1 !== 32'hAA || bus.readData2 !== 32'hBB) begin n_err++; $display("FAIL fwd_rd0: got %h/%h want aa/bb", bus.readData1, bus.readData2); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    logic exp_h;
    // lw $8, 0($1)
    set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'b000000, 2'b00, 6'b101101);
    step();
    set_id(1'b1, 5'd8, 5'd2, 5'd5, 32'd1, 32'd2, 32'd0, 5'd0, 6'b100000, 2'b10, 6'b011000);
    #1;
    n_cmp++; if (bus.loadUseHazard !== 1'b1) begin n_err++; $display("FAIL lu_detect: got %b want 1", bus.loadUseHazard); end
    bus.hold = 1'b1;
    step();
    n_cmp++; if (bus.ex_MemRead !== 1'b1 || bus.ex_writeReg !== 5'd8) begin n_err++; $display("FAIL lu_hold: got %b/%0d want 1/8", bus.ex_MemRead, bus.ex_writeReg); end
    bus.hold = 1'b0;
    step();
    n_cmp++; if ({bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg, bus.ALUCtr} !== 8'h00) begin n_err++; $display("FAIL lu_bubble: got %b want 00000000", {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg, bus.ALUCtr}); end
    n_cmp++; if (bus.loadUseHazard !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", bus.loadUseHazard); end
    // lw $0 followed by a reader of $0
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'b000000, 2'b00, 6'b101101);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 5'd0, 6'b100000, 2'b10, 6'b011000);
    #1;
    n_cmp++; if (bus.loadUseHazard !== 1'b0 || bus.ex_MemRead !== 1'b1) begin n_err++; $display("FAIL lu_reg0: got %b/%b want 0/1", bus.loadUseHazard, bus.ex_MemRead); end
    // add $5 in EX, then ID reads $5: only the stall interlock reacts
    step();
    set_id(1'b1, 5'd5, 5'd1, 5'd6, 32'd0, 32'd0, 32'd0, 5'd0, 6'b100000, 2'b10, 6'b011000);
    #1;
    exp_h = FWD ? 1'b0 : 1'b1;
    n_cmp++; if (bus.loadUseHazard !== exp_h) begin n_err++; $display("FAIL lu_alu_dep: got %b want %b", bus.loadUseHazard, exp_h); end
    bus.id_rs = 5'd1;  bus.id_rt = 5'd6;
    bus.exmem_RegWrite = 1'b1;  bus.exmem_rd = 5'd6;
    #1;
    n_cmp++; if (bus.loadUseHazard !== exp_h) begin n_err++; $display("FAIL lu_exmem_dep: got %b want %b", bus.loadUseHazard, exp_h); end
    clear_fwd();
  endtask

  task automatic test_flush_hold();
    // sw $2, 4($1)
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h11, 32'h55, 32'd4, 5'd0, 6'b000000, 2'b00, 6'b100010);
    bus.flush = 1'b1;
    step();
    n_cmp++; if (bus.ex_MemWrite !== 1'b0 || bus.readData2 !== 32'd0 || bus.ALUCtr !== 4'b0000) begin n_err++; $display("FAIL flush_sw: got %b/%h/%b want 0/0/0000", bus.ex_MemWrite, bus.readData2, bus.ALUCtr); end
    bus.flush = 1'b0;
    step();
    n_cmp++; if (bus.ex_MemWrite !== 1'b1 || bus.readData2 !== 32'd4 || bus.ex_storeData !== 32'h55) begin n_err++; $display("FAIL load_sw: got %b/%h/%h want 1/4/55", bus.ex_MemWrite, bus.readData2, bus.ex_storeData); end
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 6'b100000, 2'b10, 6'b011000);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.ex_MemWrite !== 1'b1 || bus.readData2 !== 32'd4 || bus.ex_RegWrite !== 1'b0) begin n_err++; $display("FAIL hold_%0d: got %b/%h/%b want 1/4/0", i, bus.ex_MemWrite, bus.readData2, bus.ex_RegWrite); end
    end
    bus.hold = 1'b0;
    step();
    n_cmp++; if (bus.ex_MemWrite !== 1'b0 || bus.ex_RegWrite !== 1'b1 || bus.readData2 !== 32'd7) begin n_err++; $display("FAIL hold_resume: got %b/%b/%h want 0/1/7", bus.ex_MemWrite, bus.ex_RegWrite, bus.readData2); end
  endtask

  task automatic test_alu_ctrl();
    logic [11:0] v;
    for (int i = 0; i < 12; i++) begin
      v = ALU_VEC[i];
      set_id(1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 5'd3, v[9:4], v[11:10], 6'b011000);
      step();
      n_cmp++; if (bus.ALUCtr !== v[3:0]) begin n_err++; $display("FAIL aluctr_%0d: got %b want %b", i, bus.ALUCtr, v[3:0]); end
    end
    n_cmp++; if (bus.shamt !== 5'd3) begin n_err++; $display("FAIL shamt: got %0d want 3", bus.shamt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_load_use();
    test_flush_hold();
    test_alu_ctrl();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
